rewind_replay: RTL
==================

Name: rewind_replay

Overview:
- Consumes the rewind stream the store-rewind queue emits on a ROB resteer.
- Restores speculatively overwritten cache data by replaying each store's saved old data into the cache write port.
- Entries arrive oldest-first, and pre-store data must be restored youngest-first, so the block collects the whole burst in a LIFO and then drains it.
- Sits between the rewind queue output and the cache's write-port arbiter; stalls the load/store pipeline while active.

Parameters:
- OOO_TAG_SIZE, 10, width of the out-of-order tag carried with each entry
- DEPTH, 8, LIFO entries; power of two; must be >= rewind queue depth
- QUIET_CYCLES, 2, consecutive idle rw_valid cycles that close a collect window (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rob_resteer  in  1  resteer pulse; opens the collect window
- rw_valid  in  1  rewind entry valid; no backpressure, must be accepted
- rw_addr  in  32  store address
- rw_data  in  32  pre-store (old) data to restore
- rw_op  in  3  original operation code (ST=2 expected)
- rw_size  in  2  0=byte, 1=half, 2=word, 3=reserved
- rw_tag  in  OOO_TAG_SIZE  OOO tag of the rewound store
- cache_req  out  1  replay write request
- cache_addr  out  32  word-aligned address ({rw_addr[31:2],2'b00})
- cache_wdata  out  32  old data, byte-lane aligned
- cache_be  out  4  byte enables
- cache_tag  out  OOO_TAG_SIZE  tag of the entry being replayed
- cache_ack  in  1  cache accepted the current request
- stall  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse after the last ack of a burst
- err  out  1  sticky: overflow, reserved size, rw_op!=ST, or rw_valid during DRAIN

Behaviour:
- Reset: all outputs 0, state IDLE, LIFO pointer 0, quiet counter 0, err cleared. Reset mid-burst discards all entries with no further cache_req.
- States: IDLE, COLLECT, DRAIN.
- IDLE -> COLLECT on rob_resteer or rw_valid. An rw_valid in that same cycle is pushed.
- COLLECT:
  - rw_valid pushes the entry and clears the quiet counter; otherwise the counter increments.
  - When the counter reaches QUIET_CYCLES: go to DRAIN if the LIFO is non-empty, else go to IDLE with no done pulse.
  - rob_resteer in COLLECT resets the quiet counter only.
- Overflow: a push while holding DEPTH entries is dropped and sets err. Contents are unchanged.
- DRAIN:
  - cache_req rises the first cycle in DRAIN, with the top-of-LIFO payload.
  - Payload stays stable while cache_req=1 and cache_ack=0.
  - On an ack cycle the entry pops. If entries remain, the next cycle presents the next entry with cache_req still high (one entry per cycle at most). If the LIFO is now empty, the next cycle has cache_req=0, done=1, state IDLE.
  - rw_valid during DRAIN is dropped and sets err.
  - cache_ack while cache_req=0 is ignored.
- Lane formatting, off = rw_addr[1:0]:
  - byte: be = 1<<off; wdata = data[7:0] replicated to all lanes.
  - half: be = 4'b0011<<off[1]*2; wdata = {2{data[15:0]}}. off[0]=1 is misaligned: err set and entry treated as word.
  - word: be = 4'hF; wdata = data.
  - reserved size: err set, be = 0, entry still consumes a request slot.
- Entries with rw_op!=ST set err but are replayed normally.

Optional Feature:
- REWIND_REPLAY_STATS_EN defined:
  - Adds output stat_replays (16 bits), a saturating count of acked replays since reset.
  - Adds output stat_max_depth (log2(DEPTH)+1 bits), the largest LIFO occupancy seen.
- Undefined: both ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared cache package holds:
  - operation codes: NO_OP=0, LD=1, ST=2, RD=3, WR=4, INV=5, UPD=6, WR_LD=7
  - size encodings
  - state encodings for IDLE/COLLECT/DRAIN
  - the size/offset-to-byte-enable function
- One sub-module, rewind_lifo: push/pop, count, full and empty, with an entry of {addr, data, op, size, tag}.
- The FSM and lane formatting live in the top module.

Test Plan:
- Single-entry burst:
  - Stimulus: resteer; push word at 0x100, data 0xDEADBEEF; ack at first req.
  - Required: req with addr 0x100, be F, wdata DEADBEEF; done on the cycle after the ack; stall low afterwards.
- Same-address ordering:
  - Stimulus: push byte 0x103 with old data 0x11, then byte 0x103 with old data 0x22; ack immediately.
  - Required: first req wdata 0x22222222 with be 1000, second 0x11111111; the final memory byte is 0x11.
- Backpressure:
  - Stimulus: 3 entries; ack held low for 4 cycles on each.
  - Required: payload stable while waiting; exactly 3 acked reqs; reqs issued in LIFO order.
- Overflow:
  - Stimulus: DEPTH+1 pushes back-to-back.
  - Required: err=1; exactly DEPTH replays; the last push is the one dropped.
- Empty window and reset:
  - Stimulus: resteer with no rw_valid for QUIET_CYCLES.
  - Required: return to IDLE, no done.
  - Stimulus: rst asserted mid-DRAIN.
  - Required: cache_req 0 the next cycle and no further requests.
- Half-word lanes:
  - Stimulus: size 1 at offset 2, data 0xABCD.
  - Required: be 1100, wdata 0xABCDABCD.
  - Stimulus: offset 1.
  - Required: err set.

Source files
------------

// File: rtl/rewind_replay_pkg.sv
// rewind_replay_pkg
// Shared definitions for the rewind replay block:
//   - cache operation codes
//   - access size encodings
//   - replay FSM state encodings
//   - the size/offset to byte-enable helper and the entry sanity check
package rewind_replay_pkg;

  // Cache operation codes
  localparam logic [2:0] OP_NO_OP = 3'd0;
  localparam logic [2:0] OP_LD    = 3'd1;
  localparam logic [2:0] OP_ST    = 3'd2;
  localparam logic [2:0] OP_RD    = 3'd3;
  localparam logic [2:0] OP_WR    = 3'd4;
  localparam logic [2:0] OP_INV   = 3'd5;
  localparam logic [2:0] OP_UPD   = 3'd6;
  localparam logic [2:0] OP_WR_LD = 3'd7;

  // Access size encodings
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } size_e;

  // Replay FSM states
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;

  // Byte enables for an access of the given size at byte offset off.
  // A misaligned half is widened to a full word so no lane is left stale.
  function automatic logic [3:0] size_to_be(input logic [1:0] size,
                                            input logic [1:0] off);
    logic [3:0] be;
    be = 4'h0;
    case (size_e'(size))
      SIZE_BYTE: be = 4'b0001 << off;
      SIZE_HALF: be = off[0] ? 4'hF : (4'b0011 << {off[1], 1'b0});
      SIZE_WORD: be = 4'hF;
      default:   be = 4'h0;
    endcase
    return be;
  endfunction

  // An entry is suspicious if it was not a store, has a reserved size,
  // or is a misaligned half-word.
  function automatic logic entry_err(input logic [2:0] op,
                                     input logic [1:0] size,
                                     input logic [1:0] off);
    return (op != OP_ST) ||
           (size_e'(size) == SIZE_RSVD) ||
           ((size_e'(size) == SIZE_HALF) && off[0]);
  endfunction

endpackage

// File: rtl/rewind_replay_if.sv
// rewind_replay_if
// Bundles the rewind stream (from the store-rewind queue) and the replay
// write port (towards the cache arbiter).
//   master : environment side - drives rw_* and cache_ack
//   slave  : replay block side - consumes rw_*, drives cache_*
// Parameter OOO_TAG_SIZE: width of the out-of-order tag.
interface rewind_replay_if #(
  parameter int OOO_TAG_SIZE = 10
);
  logic                    rw_valid;
  logic [31:0]             rw_addr;
  logic [31:0]             rw_data;
  logic [2:0]              rw_op;
  logic [1:0]              rw_size;
  logic [OOO_TAG_SIZE-1:0] rw_tag;

  logic                    cache_req;
  logic [31:0]             cache_addr;
  logic [31:0]             cache_wdata;
  logic [3:0]              cache_be;
  logic [OOO_TAG_SIZE-1:0] cache_tag;
  logic                    cache_ack;

  modport master (
    output rw_valid, rw_addr, rw_data, rw_op, rw_size, rw_tag,
    input  cache_req, cache_addr, cache_wdata, cache_be, cache_tag,
    output cache_ack
  );

  modport slave (
    input  rw_valid, rw_addr, rw_data, rw_op, rw_size, rw_tag,
    output cache_req, cache_addr, cache_wdata, cache_be, cache_tag,
    input  cache_ack
  );
endinterface

// File: rtl/rewind_replay_lifo.sv
// rewind_lifo
// Simple stack used to reverse the oldest-first rewind burst.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (empties the stack)
//   push/wdata - push an entry (ignored when full)
//   pop        - drop the top entry (ignored when empty)
//   rdata      - current top-of-stack entry (undefined when empty)
//   count      - occupancy, 0..DEPTH
//   full/empty - occupancy flags
module rewind_lifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    top_idx;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign top_idx = count[AW-1:0] - 1'b1;
  assign rdata   = mem[top_idx];

  // Storage is not reset; only the occupancy matters after reset.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[count[AW-1:0]] <= wdata;
    end
  end

  // Push wins if both are requested; the controller never does both.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + 1'b1;
    end else if (pop && !empty) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/rewind_replay.sv
// rewind_replay
// Collects a rewind burst from the store-rewind queue into a LIFO and
// replays each entry's old data into the cache write port youngest-first,
// undoing speculative stores after a ROB resteer.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   rob_resteer    - resteer pulse, opens/extends the collect window
//   bus (slave)    - rw_* rewind stream in, cache_* replay write port out
//   stall          - high whenever the block is not idle
//   done           - one-cycle pulse after the last ack of a burst
//   err            - sticky error (overflow, bad entry, rw_valid in drain)
// Optional (macro REWIND_REPLAY_STATS_EN):
//   stat_replays   - saturating count of acked replays
//   stat_max_depth - highest LIFO occupancy observed
module rewind_replay
  import rewind_replay_pkg::*;
#(
  parameter int OOO_TAG_SIZE = 10,
  parameter int DEPTH        = 8,
  parameter int QUIET_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rob_resteer,
  rewind_replay_if.slave         bus,
  output logic                   stall,
  output logic                   done,
  output logic                   err
`ifdef REWIND_REPLAY_STATS_EN
  ,
  output logic [15:0]            stat_replays,
  output logic [$clog2(DEPTH):0] stat_max_depth
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 32 + 32 + 3 + 2 + OOO_TAG_SIZE;
  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam logic [QW-1:0] QUIET_MAX = QW'(QUIET_CYCLES);

  logic [1:0]              state;
  logic [QW-1:0]           quiet_cnt;
  logic                    accepting;
  logic                    push;
  logic                    pop;
  logic [EW-1:0]           push_entry;
  logic [EW-1:0]           top_entry;
  logic [AW:0]             count;
  logic                    full;
  logic                    empty;

  logic [31:0]             top_addr;
  logic [31:0]             top_data;
  logic [2:0]              top_op;
  logic [1:0]              top_size;
  logic [OOO_TAG_SIZE-1:0] top_tag;
  logic [3:0]              top_be;
  logic [31:0]             top_wdata;

  assign accepting  = (state == S_IDLE) || (state == S_COLLECT);
  assign push       = bus.rw_valid && accepting && !full;
  assign pop        = (state == S_DRAIN) && bus.cache_ack;
  assign push_entry = {bus.rw_addr, bus.rw_data, bus.rw_op, bus.rw_size, bus.rw_tag};
  assign {top_addr, top_data, top_op, top_size, top_tag} = top_entry;

  rewind_lifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (top_entry),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Lane formatting of the top entry. Misaligned halves are replayed as
  // full words; reserved sizes keep a request slot but write no lanes.
  always_comb begin
    top_be    = size_to_be(top_size, top_addr[1:0]);
    top_wdata = top_data;
    case (size_e'(top_size))
      SIZE_BYTE: top_wdata = {4{top_data[7:0]}};
      SIZE_HALF: top_wdata = top_addr[0] ? top_data : {2{top_data[15:0]}};
      default:   top_wdata = top_data;
    endcase
  end

  // Payload is forced to zero outside DRAIN so idle outputs never show
  // stale or uninitialised stack contents.
  always_comb begin
    bus.cache_req   = (state == S_DRAIN);
    bus.cache_addr  = '0;
    bus.cache_wdata = '0;
    bus.cache_be    = '0;
    bus.cache_tag   = '0;
    if (state == S_DRAIN) begin
      bus.cache_addr  = {top_addr[31:2], 2'b00};
      bus.cache_wdata = top_wdata;
      bus.cache_be    = top_be;
      bus.cache_tag   = top_tag;
    end
  end

  assign stall = (state != S_IDLE);

  // Bad entries are flagged as they are replayed; every stored entry is
  // replayed unless reset intervenes, and reset clears err anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((bus.rw_valid && ((state == S_DRAIN) || full)) ||
                 ((state == S_DRAIN) && entry_err(top_op, top_size, top_addr[1:0]))) begin
      err <= 1'b1;
    end
  end

  // Collect window closes after QUIET_CYCLES consecutive cycles with no
  // rw_valid and no resteer; an empty window returns silently to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      quiet_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          quiet_cnt <= '0;
          if (rob_resteer || bus.rw_valid) begin
            state <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (bus.rw_valid || rob_resteer) begin
            quiet_cnt <= '0;
          end else if (quiet_cnt + 1'b1 == QUIET_MAX) begin
            quiet_cnt <= '0;
            state     <= empty ? S_IDLE : S_DRAIN;
          end else begin
            quiet_cnt <= quiet_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (bus.cache_ack && (count == (AW+1)'(1))) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          quiet_cnt <= '0;
        end
      endcase
    end
  end

`ifdef REWIND_REPLAY_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_replays   <= '0;
      stat_max_depth <= '0;
    end else begin
      if (pop && (stat_replays != 16'hFFFF)) begin
        stat_replays <= stat_replays + 16'd1;
      end
      if (count > stat_max_depth) begin
        stat_max_depth <= count;
      end
    end
  end
`endif

endmodule
